// File: rtl/bfloat_mac_feeder.sv
// Joins bfloat16 A/B operand streams into a small pair FIFO and issues len tagged pairs per vector.
// Optional BF_FEEDER_DENORM_FLUSH_EN: subnormal operands are flushed to signed zero at FIFO write.
module bfloat_mac_feeder #(
   parameter int DEPTH = 4,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [15:0]      a_data,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [15:0]      b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic [15:0]      mac_a,
   output logic [15:0]      mac_b,
   output logic             mac_valid,
   input  logic             mac_ready,
   output logic             mac_first,
   output logic             mac_last,
   output logic             busy,
   output logic             done
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state;
   logic [LEN_W-1:0] remaining;
   logic [LEN_W-1:0] len_lat;
   logic [33:0]      mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             accept;
   logic             push;
   logic             pop;
   logic [33:0]      head;
   logic [33:0]      wr_entry;

   function automatic logic [15:0] conv(input logic [15:0] v);
`ifdef BF_FEEDER_DENORM_FLUSH_EN
      if (v[14:7] == 8'd0 && v[6:0] != 7'd0) return {v[15], 15'd0};
`endif
      return v;
   endfunction

   always_comb begin
      empty    = (count == '0);
      full     = (count == CW'(DEPTH));
      accept   = (state == RUN) && (remaining != '0) && !full;
      a_ready  = accept && b_valid;
      b_ready  = accept && a_valid;
      push     = accept && a_valid && b_valid;
      pop      = !empty && mac_ready;
      head     = mem[rd_ptr];
      wr_entry = {conv(a_data), conv(b_data), (remaining == len_lat), (remaining == LEN_W'(1))};
      busy     = (state != IDLE);
      mac_valid = !empty;
      // Head is gated so an empty FIFO never exposes stale entries.
      {mac_a, mac_b, mac_first, mac_last} = empty ? '0 : head;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         len_lat   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
         case (state)
            IDLE: begin
               if (start && len != '0) begin
                  remaining <= len;
                  len_lat   <= len;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (push) begin
                  remaining <= remaining - 1'b1;
                  if (remaining == LEN_W'(1)) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && head[0]) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

endmodule

// File: tb/tb_bfloat_mac_feeder.sv
// Self-checking bench for bfloat_mac_feeder: randomized sources and sink against a queue-based pairing model.
module tb_bfloat_mac_feeder;
   localparam int DEPTH = 4;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst, start;
   logic [LEN_W-1:0] len;
   logic [15:0]      a_data, b_data;
   logic             a_valid, b_valid, a_ready, b_ready;
   logic [15:0]      mac_a, mac_b;
   logic             mac_valid, mac_ready, mac_first, mac_last, busy, done;

   always #5 clk = ~clk;

   bfloat_mac_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
      .mac_a(mac_a), .mac_b(mac_b), .mac_valid(mac_valid), .mac_ready(mac_ready),
      .mac_first(mac_first), .mac_last(mac_last), .busy(busy), .done(done)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        first;
      logic        last;
   } pair_t;

   pair_t       q[$];
   logic [15:0] a_force[$];
   int checks = 0, errors = 0;
   bit active = 0, done_exp = 0;
   int joins = 0, cur_len = 0, cyc = 0, dut_joins = 0;
   int a_pct = 100, b_pct = 100, r_pct = 100, b_every = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_op(input logic [15:0] v);
`ifdef BF_FEEDER_DENORM_FLUSH_EN
      if (v[14:7] == 8'd0 && v[6:0] != 7'd0) return {v[15], 15'd0};
`endif
      return v;
   endfunction

   function automatic logic [15:0] rnd_op();
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(3) == 0) v[14:7] = '0;
      return v;
   endfunction

   task automatic drive_sources(input logic joined);
      if (joined) begin
         a_data = (a_force.size() != 0) ? a_force.pop_front() : rnd_op();
         b_data = rnd_op();
      end
      if (!(a_valid && !joined)) a_valid = (int'($urandom_range(99)) < a_pct);
      if (!(b_valid && !joined))
         b_valid = (b_every != 0) ? (cyc % b_every == 0) : (int'($urandom_range(99)) < b_pct);
      mac_ready = (int'($urandom_range(99)) < r_pct);
   endtask

   // One clock: check every output against the model, then advance the model across the edge.
   task automatic tick();
      logic  exp_ar, exp_br, join_now, pop_now;
      pair_t p;
      @(negedge clk);
      exp_ar = active && (joins < cur_len) && (q.size() < DEPTH) && b_valid;
      exp_br = active && (joins < cur_len) && (q.size() < DEPTH) && a_valid;
      chk("a_ready", a_ready, exp_ar);
      chk("b_ready", b_ready, exp_br);
      chk("mac_valid", mac_valid, q.size() != 0);
      if (q.size() != 0) begin
         p = q[0];
         chk("mac_a", mac_a, p.a);
         chk("mac_b", mac_b, p.b);
         chk("mac_first", mac_first, p.first);
         chk("mac_last", mac_last, p.last);
      end else begin
         chk("idle_mac_a", mac_a, 0);
         chk("idle_mac_b", mac_b, 0);
         chk("idle_flags", {mac_first, mac_last}, 0);
      end
      chk("done", done, done_exp);
      chk("busy", busy, active);
      if (a_valid && a_ready && b_valid && b_ready) dut_joins++;
      join_now = a_valid && exp_ar;
      pop_now  = (q.size() != 0) && mac_ready;
      done_exp = 0;
      if (rst) begin
         q.delete();
         active   = 0;
         joins    = 0;
         cur_len  = 0;
         join_now = 0;
      end else begin
         if (start && !active && len != '0) begin
            active  = 1;
            joins   = 0;
            cur_len = int'(len);
         end
         if (pop_now) begin
            p = q.pop_front();
            if (p.last) begin
               active   = 0;
               done_exp = 1;
            end
         end
         if (join_now) begin
            q.push_back('{model_op(a_data), model_op(b_data), joins == 0, joins == cur_len - 1});
            joins++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      drive_sources(join_now);
   endtask

   task automatic start_vec(input int n);
      len   = LEN_W'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic finish_vec(input int budget);
      int i;
      i = 0;
      while ((active || done_exp) && i < budget) begin
         tick();
         i++;
      end
      chk("vector_completes", busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; len = '0;
      a_data = rnd_op(); b_data = rnd_op();
      a_valid = 1'b0; b_valid = 1'b0; mac_ready = 1'b0;
      @(posedge clk); #1;
      tick();
      rst = 1'b0;
      tick();

      // len=3, both sources always valid, free-running MAC
      a_valid = 1'b1; b_valid = 1'b1; mac_ready = 1'b1;
      start_vec(3);
      finish_vec(50);

      // single-pair vector carries both first and last
      start_vec(1);
      finish_vec(50);

      // MAC stalled: FIFO fills to DEPTH then sources are back-pressured
      r_pct = 0; mac_ready = 1'b0; dut_joins = 0;
      start_vec(8);
      repeat (10) tick();
      chk("full_buffered_pairs", dut_joins, DEPTH);
      chk("full_a_ready", a_ready, 0);
      chk("full_b_ready", b_ready, 0);
      r_pct = 100; mac_ready = 1'b1;
      finish_vec(100);

      // A always valid, B valid every third cycle
      b_every = 3;
      start_vec(6);
      finish_vec(200);
      b_every = 0;

      // len=0 start is ignored
      start_vec(0);
      tick();
      chk("len0_busy", busy, 0);

      // start during RUN ignored, then reset after two joins
      a_pct = 100; b_pct = 100;
      start_vec(5);
      len = LEN_W'(2); start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 50 && joins < 2; i++) tick();
      chk("joins_before_reset", joins >= 2, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("post_reset_mac_valid", mac_valid, 0);
      chk("post_reset_ready", {a_ready, b_ready}, 0);
      tick();
      start_vec(2);
      finish_vec(50);

      // operand pass-through / subnormal flush on A
      a_data = 16'h8001;
      a_force.push_back(16'h3F80);
      start_vec(2);
      finish_vec(50);

      // randomized vectors with random stalls on both sides
      for (int v = 0; v < 12; v++) begin
         a_pct = int'($urandom_range(100, 30));
         b_pct = int'($urandom_range(100, 30));
         r_pct = int'($urandom_range(100, 20));
         start_vec(int'($urandom_range(20, 1)));
         finish_vec(2000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
